// File: rtl/bus_mem_responder.sv
// Burst memory responder: 8-beat line writes and reads with a fixed read latency.
// Optional respack checking is enabled by defining BUS_RESP_CHECK_EN.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LOG_MEM_LINES  = 8,
  parameter int MEM_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respack,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      proto_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_RRESP = 2'd3;

  localparam int         READ_BIT  = 12;
  localparam int         ADDR_BITS = LOG_MEM_LINES + 3;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

  logic [1:0]                state;
  logic [LOG_MEM_LINES-1:0]  line_idx;
  logic [2:0]                beat_cnt;
  logic [3:0]                wait_cnt;
  logic [BUS_TAG_WIDTH-1:0]  read_tag;
  logic [BUS_DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  logic                      accept;
  logic                      is_read;
  logic                      mem_we;
  logic [2:0]                rd_sel;
  logic [BUS_DATA_WIDTH-1:0] rd_word;

  // A beat is taken only while reqack is low, so a held beat is never taken twice back-to-back.
  assign accept  = bus_reqcyc && !bus_reqack && (state == S_IDLE || state == S_WDATA);
  assign is_read = bus_reqtag[READ_BIT];
  assign mem_we  = accept && (state == S_WDATA) && !reset;

  // Fetch the word that will be shown on the next cycle.
  assign rd_sel  = (state == S_RRESP) ? beat_cnt + 3'd1 : 3'd0;
  assign rd_word = mem[{line_idx, rd_sel}];

  // NOTE: storage has no reset branch; contents must survive reset and a RAM cannot be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{line_idx, beat_cnt}] <= bus_req;
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values, as the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      line_idx    <= '0;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      read_tag    <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
    end else begin
      bus_reqack <= accept;
      case (state)
        S_IDLE: begin
          if (accept) begin
            line_idx <= bus_req[LOG_MEM_LINES+5:6];
            beat_cnt <= 3'd0;
            if (is_read) begin
              read_tag <= bus_reqtag;
              wait_cnt <= 4'd0;
              state    <= S_RWAIT;
            end else begin
              state <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (beat_cnt == 3'd7) state <= S_IDLE;
          end
        end
        S_RWAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state       <= S_RRESP;
            beat_cnt    <= 3'd0;
            bus_respcyc <= 1'b1;
            bus_resp    <= rd_word;
            bus_resptag <= read_tag;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RRESP: begin
          if (beat_cnt == 3'd7) begin
            state       <= S_IDLE;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
          end else begin
            beat_cnt <= beat_cnt + 3'd1;
            bus_resp <= rd_word;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BUS_RESP_CHECK_EN
  logic resp_d;

  // An ack must follow every beat by one cycle; an ack without a beat is equally an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_d    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      resp_d <= bus_respcyc;
      if (resp_d != bus_respack) proto_err <= 1'b1;
    end
  end
`else
  logic unused_respack;

  assign unused_respack = bus_respack;
  assign proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: write/read bursts, stalls, aliasing, reset and respack checking.
module tb_bus_mem_responder;

  typedef logic [63:0] line_t [8];

`ifdef BUS_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_respack = 1'b0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        proto_err;

  int vectors = 0;
  int miscompares = 0;
  int ack_pulses = 0;
  int skip_beat = -1;

  bus_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_respack(bus_respack),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_reqack) ack_pulses++;

  // Initiator side of the response handshake: ack each beat one cycle later, except skip_beat.
  logic seen = 1'b0;
  int   seen_idx = 0;
  int   run_idx = 0;
  always begin
    @(negedge clk);
    seen = bus_respcyc;
    if (bus_respcyc) begin
      seen_idx = run_idx;
      run_idx++;
    end else begin
      run_idx = 0;
    end
    @(posedge clk);
    #1;
    bus_respack = seen && (seen_idx != skip_beat);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns during the cycle in which reqack is seen.
  task automatic send_beat(input logic [63:0] data, input logic [12:0] tag);
    logic got = 1'b0;
    bus_reqcyc = 1'b1;
    bus_req    = data;
    bus_reqtag = tag;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      got = bus_reqack;
    end
    bus_reqcyc = 1'b0;
    if (!got) check("reqack_timeout", 64'(got), 64'd1);
  endtask

  task automatic write_line(input logic [63:0] addr, input line_t d, input int gap);
    send_beat(addr, 13'h0005);
    for (int k = 0; k < 8; k++) begin
      repeat (gap) step();
      send_beat(d[k], 13'h0005);
    end
  endtask

  // Starts in the reqack cycle of a read; checks latency, 8 beats and the idle tail.
  task automatic collect_resp(input string name, input logic [12:0] tag, input line_t exp,
                              output logic [7:0] pf);
    int lat = 0;
    pf = '0;
    while (!bus_respcyc && lat < 40) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    if (!bus_respcyc) return;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_beat%0d", name, k), bus_resp, exp[k]);
      check($sformatf("%s_tag%0d", name, k), 64'(bus_resptag), 64'(tag));
      pf[k] = proto_err;
      if (k < 7) step();
    end
    step();
    check({name, "_tail_cyc"}, 64'(bus_respcyc), 64'd0);
    check({name, "_tail_resp"}, bus_resp, 64'd0);
    check({name, "_tail_tag"}, 64'(bus_resptag), 64'd0);
  endtask

  task automatic read_line(input string name, input logic [63:0] addr, input logic [12:0] tag,
                           input line_t exp, output logic [7:0] pf);
    send_beat(addr, tag);
    collect_resp(name, tag, exp, pf);
  endtask

  initial begin
    line_t       a_data, b_data, old_d, new_d, mix_d;
    logic [7:0]  pf;
    logic        got;
    int          n;

    a_data = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
    for (int k = 0; k < 8; k++) begin
      b_data[k] = 64'hA0A0_0000_0000_0000 + 64'(k);
      old_d[k]  = 64'h0000_0000_0000_A000 + 64'(k);
      new_d[k]  = 64'h0000_0000_0000_B000 + 64'(k);
      mix_d[k]  = (k < 4) ? new_d[k] : old_d[k];
    end

    repeat (3) step();
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    check("rst_proto", 64'(proto_err), 64'd0);
    reset = 1'b0;
    step();

    // Basic write then read of line 0x40.
    ack_pulses = 0;
    write_line(64'h1000, a_data, 0);
    step();
    check("wr_ack_pulses", 64'(ack_pulses), 64'd9);
    read_line("rd_basic", 64'h1000, 13'h1103, a_data, pf);

    // Slow initiator: three idle cycles between beats.
    ack_pulses = 0;
    write_line(64'h1040, b_data, 3);
    step();
    check("hold_ack_pulses", 64'(ack_pulses), 64'd9);
    read_line("rd_hold", 64'h1040, 13'h1004, b_data, pf);

    // Second read requested while the first is still streaming.
    send_beat(64'h1000, 13'h1010);
    n = 0;
    while (!bus_respcyc && n < 40) begin
      step();
      n++;
    end
    check("stall_first_beat", 64'(bus_respcyc), 64'd1);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h1040;
    bus_reqtag = 13'h1011;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stall_a_beat%0d", k), bus_resp, a_data[k]);
      check($sformatf("stall_reqack%0d", k), 64'(bus_reqack), 64'd0);
      if (k < 7) step();
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = bus_reqack;
    end
    bus_reqcyc = 1'b0;
    check("stall_b_accepted", 64'(got), 64'd1);
    collect_resp("stall_b", 13'h1011, b_data, pf);

    // Address bits above the index and below bit 6 are ignored.
    read_line("alias_hi", 64'h41000, 13'h1020, a_data, pf);
    read_line("alias_lo", 64'h1000_0000_0000_103F, 13'h1021, a_data, pf);

    // Reset while write beat 4 is being offered.
    write_line(64'h1080, old_d, 0);
    send_beat(64'h1080, 13'h0006);
    for (int k = 0; k < 4; k++) send_beat(new_d[k], 13'h0006);
    step();
    bus_reqcyc = 1'b1;
    bus_req    = new_d[4];
    bus_reqtag = 13'h0006;
    reset      = 1'b1;
    step();
    check("midrst_reqack", 64'(bus_reqack), 64'd0);
    check("midrst_respcyc", 64'(bus_respcyc), 64'd0);
    check("midrst_resp", bus_resp, 64'd0);
    check("midrst_proto", 64'(proto_err), 64'd0);
    reset      = 1'b0;
    bus_reqcyc = 1'b0;
    step();
    read_line("rd_after_rst", 64'h1080, 13'h1030, mix_d, pf);
    check("proto_clean", 64'(proto_err), 64'd0);

    // Withhold the ack for beat 2.
    skip_beat = 2;
    read_line("rd_noack", 64'h1000, 13'h1040, a_data, pf);
    skip_beat = -1;
    check("proto_before", 64'(pf[3]), 64'd0);
    check("proto_set", 64'(pf[4]), 64'(EXP_ERR));
    check("proto_hold_b7", 64'(pf[7]), 64'(EXP_ERR));
    repeat (5) step();
    check("proto_sticky", 64'(proto_err), 64'(EXP_ERR));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("proto_cleared", 64'(proto_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
